dm_m: RTL and testbench

DM_M -- requirements
Module: dm_M

---
 rtl/dm_m.sv | 100 ++++++++++
 tb/tb_dm_m.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dm_m.sv
// M-stage data memory: 4096 x 32-bit words, combinational read, byte/half/word stores.
// Optional DM_ALIGN_CHECK_EN flags misaligned or out-of-range accesses and suppresses their writes.
module dm_m (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite_M,
  input  logic [3:0]  DM_sel_M,
  output logic [31:0] rdata,
  output logic        addr_err
);

  typedef enum logic [3:0] {
    SEL_LB   = 4'd0,
    SEL_LBU  = 4'd1,
    SEL_LH   = 4'd2,
    SEL_LHU  = 4'd3,
    SEL_LW   = 4'd4,
    SEL_SB   = 4'd5,
    SEL_SH   = 4'd6,
    SEL_SW   = 4'd7,
    SEL_NONE = 4'd15
  } dm_sel_e;

  logic [31:0] mem [4096];

  dm_sel_e     sel;
  logic [11:0] idx;
  logic [31:0] word;
  logic [31:0] merged;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        is_store;
  logic        do_write;

  assign sel      = dm_sel_e'(DM_sel_M);
  assign idx      = addr[13:2];
  assign word     = mem[idx];
  assign byte_v   = word[{addr[1:0], 3'b000} +: 8];
  assign half_v   = addr[1] ? word[31:16] : word[15:0];
  assign is_store = (sel == SEL_SB) || (sel == SEL_SH) || (sel == SEL_SW);

`ifdef DM_ALIGN_CHECK_EN
  always_comb begin
    addr_err = 1'b0;
    if ((sel == SEL_LH || sel == SEL_LHU || sel == SEL_SH) && addr[0])
      addr_err = 1'b1;
    if ((sel == SEL_LW || sel == SEL_SW) && (addr[1:0] != 2'b00))
      addr_err = 1'b1;
    // Only codes 0..7 are real accesses; 8..15 behave as none.
    if ((DM_sel_M <= 4'd7) && (addr[31:14] != 18'd0))
      addr_err = 1'b1;
  end
`else
  assign addr_err = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr[31:14]};
`endif

  assign do_write = MemWrite_M && is_store && !addr_err;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    rdata = word;
    case (sel)
      SEL_LB:  rdata = {{24{byte_v[7]}}, byte_v};
      SEL_LBU: rdata = {24'd0, byte_v};
      SEL_LH:  rdata = {{16{half_v[15]}}, half_v};
      SEL_LHU: rdata = {16'd0, half_v};
      default: rdata = word;
    endcase
  end

  // Read-modify-write: untouched lanes keep the current word's contents.
  always_comb begin
    merged = word;
    case (sel)
      SEL_SB:  merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      SEL_SH:  merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      SEL_SW:  merged = wdata;
      default: merged = word;
    endcase
  end

  // NOTE: the whole array is cleared on reset, so this maps to flops rather than a block RAM.
  // NOTE: sequential state uses non-blocking assignments so same-cycle reads see the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, PC_M, {18'b0, addr[13:2], 2'b00}, merged);
`endif
    end
  end

endmodule

// File: tb/tb_dm_m.sv
// Directed self-checking bench for dm_m; build with +define+DM_ALIGN_CHECK_EN to cover the check mode.
module tb_dm_m;

  logic        clk;
  logic        reset;
  logic [31:0] PC_M;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWrite_M;
  logic [3:0]  DM_sel_M;
  logic [31:0] rdata;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  dm_m dut (
    .clk        (clk),
    .reset      (reset),
    .PC_M       (PC_M),
    .addr       (addr),
    .wdata      (wdata),
    .MemWrite_M (MemWrite_M),
    .DM_sel_M   (DM_sel_M),
    .rdata      (rdata),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4,
                         SB = 4'd5, SH = 4'd6, SW = 4'd7, NONE = 4'd15;

  task automatic drive(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                       input logic we);
    DM_sel_M   = s;
    addr       = a;
    wdata      = d;
    MemWrite_M = we;
    PC_M       = PC_M + 32'd4;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    MemWrite_M = 1'b0;
    DM_sel_M   = NONE;
  endtask

  task automatic store(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    drive(s, a, d, 1'b1);
    tick();
  endtask

  task automatic expect_load(input string name, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] exp);
    drive(s, a, 32'd0, 1'b0);
    checks++;
    if (rdata !== exp) begin
      errors++;
      $display("FAIL %s: rdata=%h expected=%h", name, rdata, exp);
    end
  endtask

  task automatic test_reset();
    int bad;
    // Store attempted during the reset cycle must be dropped.
    reset = 1'b1;
    drive(SW, 32'h40, 32'hDEADBEEF, 1'b1);
    tick();
    reset = 1'b0;
    expect_load("reset_store_dropped", LW, 32'h40, 32'h0);
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_addr_err: addr_err=%b expected=0", addr_err);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      drive(LW, i * 4, 32'd0, 1'b0);
      if (rdata !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_scan: nonzero_words=%0d expected=0", bad);
    end
  endtask

  task automatic test_load_ext();
    store(SW, 32'h10, 32'h80FF7F01);
    expect_load("lb_0x13",  LB,  32'h13, 32'hFFFFFF80);
    expect_load("lbu_0x13", LBU, 32'h13, 32'h00000080);
    expect_load("lb_0x10",  LB,  32'h10, 32'h00000001);
    expect_load("lbu_0x11", LBU, 32'h11, 32'h0000007F);
    expect_load("lh_0x12",  LH,  32'h12, 32'hFFFF80FF);
    expect_load("lhu_0x12", LHU, 32'h12, 32'h000080FF);
    expect_load("lh_0x10",  LH,  32'h10, 32'h00007F01);
    expect_load("none_0x10", NONE, 32'h10, 32'h80FF7F01);
  endtask

  task automatic test_merge();
    store(SW, 32'h20, 32'h11223344);
    store(SB, 32'h21, 32'h000000AB);
    expect_load("merge_sb", LW, 32'h20, 32'h1122AB44);
    store(SH, 32'h22, 32'h0000CDEF);
    expect_load("merge_sh", LW, 32'h20, 32'hCDEFAB44);
    store(SB, 32'h27, 32'hFFFFFF5A);
    expect_load("merge_sb_lane3", LW, 32'h24, 32'h5A000000);
  endtask

  task automatic test_no_write();
    store(LW, 32'h20, 32'hFFFFFFFF);
    store(4'd9, 32'h20, 32'hFFFFFFFF);
    store(NONE, 32'h20, 32'hFFFFFFFF);
    drive(SW, 32'h20, 32'hFFFFFFFF, 1'b0);
    tick();
    expect_load("no_write", LW, 32'h20, 32'hCDEFAB44);
  endtask

  task automatic test_back_to_back();
    store(SW, 32'h44, 32'h12345678);
    drive(SW, 32'h44, 32'hDEADBEEF, 1'b1);
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL same_cycle_read: rdata=%h expected=12345678", rdata);
    end
    tick();
    expect_load("after_write", LW, 32'h44, 32'hDEADBEEF);
  endtask

  task automatic test_align();
`ifdef DM_ALIGN_CHECK_EN
    drive(SW, 32'h42, 32'h00000005, 1'b1);
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL sw_misaligned_err: addr_err=%b expected=1", addr_err);
    end
    tick();
    expect_load("sw_misaligned_suppressed", LW, 32'h40, 32'h0);
    drive(LH, 32'h11, 32'd0, 1'b0);
    checks++;
    if (addr_err !== 1'b1 || rdata !== 32'h00007F01) begin
      errors++;
      $display("FAIL lh_odd: addr_err=%b rdata=%h expected=1/00007f01", addr_err, rdata);
    end
    drive(LW, 32'h00004010, 32'd0, 1'b0);
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL lw_out_of_range: addr_err=%b expected=1", addr_err);
    end
    drive(LB, 32'h13, 32'd0, 1'b0);
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL lb_any_align: addr_err=%b expected=0", addr_err);
    end
`else
    drive(SW, 32'h42, 32'h00000005, 1'b1);
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL sw_unaligned_err: addr_err=%b expected=0", addr_err);
    end
    tick();
    expect_load("sw_forced_align", LW, 32'h40, 32'h00000005);
    expect_load("high_addr_alias", LW, 32'h00004010, 32'h80FF7F01);
    expect_load("lh_forced_align", LH, 32'h13, 32'hFFFF80FF);
`endif
  endtask

  initial begin
    reset      = 1'b1;
    PC_M       = 32'h00003000;
    addr       = 32'h0;
    wdata      = 32'h0;
    MemWrite_M = 1'b0;
    DM_sel_M   = NONE;
    test_reset();
    test_load_ext();
    test_merge();
    test_no_write();
    test_back_to_back();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
